// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, frame geometry and the
// clock-divider helper used by both the transmitter and the receiver.
package uart_pkg;

  // Frame sequencer states, shared by both ends of the link
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Payload bits per frame (8-N-1)
  localparam int DATA_BITS = 8;

  // Clocks per bit period; integer division truncates toward zero
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 while enabled and raises
// tick on the last clock of every bit period; held at zero when disabled
// so each enabled run starts on a fresh bit boundary.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  // A 2-clock period still needs one counter bit
  localparam int CNT_W = ($clog2(CLKS_PER_BIT) > 0) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic             tick_s;

  // Bit-end detect: only meaningful while the counter is running
  always_comb begin
    tick_s = en && (cnt_r == CNT_LAST);
  end

  // Divider counter: zero when idle, wraps to zero on each bit-end tick
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (!en) begin
      cnt_r <= CNT_ZERO;
    end else if (tick_s) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign tick = tick_s;

endmodule

// File: rtl/uart_tx_chk.sv
// Simulation-time sanity checks for the transmitter configuration.
module uart_tx_chk #(
  parameter int CLKS_PER_BIT = 434
) (
  input logic clk
);

  // A bit period shorter than two clocks cannot be timed by the divider
  always_ff @(posedge clk) begin
    assert (CLKS_PER_BIT >= 2)
      else $error("uart_tx: CLKS_PER_BIT=%0d is below the minimum of 2", CLKS_PER_BIT);
  end

endmodule

// File: rtl/uart_tx.sv
// 8-N-1 UART transmitter. Accepts one byte per tx_start while idle,
// sends start bit, eight data bits LSB-first and a stop bit, then pulses
// tx_done for one clock. Every output comes straight from a flop so the
// serial line cannot glitch.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_pin_out
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_t          state_r;
  uart_state_t          state_nxt_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_nxt_s;
  logic [2:0]           bit_cnt_r;
  logic [2:0]           bit_cnt_nxt_s;
  logic                 pin_r;
  logic                 pin_nxt_s;
  logic                 busy_r;
  logic                 busy_nxt_s;
  logic                 done_r;
  logic                 done_nxt_s;
  logic                 tick_s;

  // The divider runs for the whole frame; busy is already high in the
  // first start-bit cycle, so the count begins at zero right on time
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk (clk),
    .rst (rst),
    .en  (busy_r),
    .tick(tick_s)
  );

  uart_tx_chk #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_chk (
    .clk(clk)
  );

  // Next-state logic: advance one frame section per bit-end tick
  always_comb begin
    state_nxt_s   = state_r;
    shift_nxt_s   = shift_r;
    bit_cnt_nxt_s = bit_cnt_r;
    case (state_r)
      IDLE: begin
        if (tx_start) begin
          state_nxt_s   = START;
          shift_nxt_s   = tx_data;
          bit_cnt_nxt_s = 3'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          shift_nxt_s   = {1'b0, shift_r[DATA_BITS-1:1]};
          // Wraps 7 -> 0 on the way into STOP
          bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == LAST_BIT) begin
            state_nxt_s = STOP;
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      STOP: begin
        if (tick_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the flops line up with it
  always_comb begin
    pin_nxt_s  = 1'b1;
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      IDLE: begin
        pin_nxt_s  = 1'b1;
        busy_nxt_s = 1'b0;
      end
      START: begin
        pin_nxt_s  = 1'b0;
        busy_nxt_s = 1'b1;
      end
      DATA: begin
        pin_nxt_s  = shift_nxt_s[0];
        busy_nxt_s = 1'b1;
      end
      STOP: begin
        pin_nxt_s  = 1'b1;
        busy_nxt_s = 1'b1;
      end
      default: begin
        pin_nxt_s  = 1'b1;
        busy_nxt_s = 1'b0;
      end
    endcase
    // Completion only when the stop bit runs to its end
    if ((state_r == STOP) && tick_s) begin
      done_nxt_s = 1'b1;
    end else begin
      done_nxt_s = 1'b0;
    end
  end

  // Frame registers; reset abandons any frame in flight immediately
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      shift_r   <= {DATA_BITS{1'b0}};
      bit_cnt_r <= 3'd0;
      pin_r     <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      shift_r   <= shift_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      pin_r     <= pin_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
    end
  end

  assign tx_pin_out = pin_r;
  assign tx_busy    = busy_r;
  assign tx_done    = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a short-bit instance (4 clocks/bit) checked by a
// mid-bit sampling receiver model against a queue of expected bytes, plus
// a default-parameter instance checked for the full 434-clock bit time.
module tb_uart_tx;

  localparam int TB_CPB  = 4;
  localparam int DEF_CPB = 434;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_busy, tx_done, tx_pin_out;

  logic       tx_start_d = 1'b0;
  logic [7:0] tx_data_d = 8'h00;
  logic       tx_busy_d, tx_done_d, tx_pin_out_d;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  int         done_cnt = 0;
  logic       rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;

  uart_tx #(.CLKS_PER_BIT(TB_CPB)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_pin_out(tx_pin_out)
  );

  uart_tx dut_def (
    .clk(clk), .rst(rst), .tx_start(tx_start_d), .tx_data(tx_data_d),
    .tx_busy(tx_busy_d), .tx_done(tx_done_d), .tx_pin_out(tx_pin_out_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected line level k cycles after the accepting edge
  function automatic logic exp_line(input logic [7:0] b, input int k, input int cpb);
    int slot;
    if (k < 1) return 1'b1;
    slot = (k - 1) / cpb;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  // Receiver model: mid-bit sampling of the short-bit instance
  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (rst) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx_pin_out === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt = 1;
      end
    end else begin
      rx_cnt++;
    end
    if (rx_active && !rst && (rx_cnt % TB_CPB == TB_CPB / 2 + 1)) begin
      int slot;
      slot = rx_cnt / TB_CPB;
      if (slot == 0) begin
        chk("rx_start_bit", tx_pin_out, 1'b0);
      end else if (slot <= 8) begin
        rx_byte[slot-1] = tx_pin_out;
      end else begin
        chk("rx_stop_bit", tx_pin_out, 1'b1);
        if (exp_q.size() == 0) chk("rx_unexpected_frame", rx_byte, 32'hFFFF_FFFF);
        else chk("rx_byte", rx_byte, exp_q.pop_front());
        rx_active = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    tx_data = b;
    tx_start = 1'b1;
    exp_q.push_back(b);
    @(posedge clk);
    #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) seen = 1'b1;
    end
    chk("done_seen", seen, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int busy_cnt;
    int done_k;

    // Reset then idle
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_pin", tx_pin_out, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_pin", tx_pin_out, 1'b1);
      chk("idle_busy", tx_busy, 1'b0);
      chk("idle_done", tx_done, 1'b0);
    end

    // Single byte 0xA5 with cycle-exact line/busy/done timing
    send(8'hA5);
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      chk("a5_line", tx_pin_out, exp_line(8'hA5, k, TB_CPB));
      chk("a5_busy", tx_busy, (k <= 10 * TB_CPB) ? 1'b1 : 1'b0);
      chk("a5_done", tx_done, (k == 10 * TB_CPB + 1) ? 1'b1 : 1'b0);
    end

    // Back-to-back 0x00 then 0xFF, second request in the done cycle
    send(8'h00);
    wait_done(100);
    chk("b2b_done_line", tx_pin_out, 1'b1);
    tx_data = 8'hFF;
    tx_start = 1'b1;
    exp_q.push_back(8'hFF);
    @(posedge clk); #1;
    tx_start = 1'b0;
    @(negedge clk);
    chk("b2b_start_next", tx_pin_out, 1'b0);
    chk("b2b_busy_next", tx_busy, 1'b1);
    wait_done(100);

    // Request during DATA is ignored; data change after capture is harmless
    repeat (5) @(negedge clk);
    d0 = done_cnt;
    send(8'h81);
    repeat (9) @(posedge clk);
    #1;
    tx_data = 8'h3C;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    wait_done(100);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("ign_idle_line", tx_pin_out, 1'b1);
      chk("ign_idle_busy", tx_busy, 1'b0);
    end
    chk("ign_single_done", done_cnt - d0, 1);

    // Reset during bit 3 of 0x55
    send(8'h55);
    repeat (17) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_front());
    d0 = done_cnt;
    @(negedge clk);
    chk("rstmid_line", tx_pin_out, 1'b1);
    chk("rstmid_busy", tx_busy, 1'b0);
    repeat (50) @(negedge clk);
    chk("rstmid_no_done", done_cnt - d0, 0);
    chk("rstmid_idle_line", tx_pin_out, 1'b1);
    send(8'h55);
    wait_done(100);
    repeat (5) @(negedge clk);

    // Default parameters: 434 clocks per bit, byte 0x4B
    @(posedge clk); #1;
    tx_data_d = 8'h4B;
    tx_start_d = 1'b1;
    @(posedge clk); #1;
    tx_start_d = 1'b0;
    busy_cnt = 0;
    done_k = 0;
    for (int k = 1; k <= 10 * DEF_CPB + 5; k++) begin
      @(negedge clk);
      if (tx_busy_d === 1'b1) busy_cnt++;
      if (tx_done_d === 1'b1 && done_k == 0) done_k = k;
      if ((k % DEF_CPB == DEF_CPB / 2 + 1) && (k / DEF_CPB < 10))
        chk("def_bit", tx_pin_out_d, exp_line(8'h4B, k, DEF_CPB));
    end
    chk("def_busy_cycles", busy_cnt, 10 * DEF_CPB);
    chk("def_done_cycle", done_k, 10 * DEF_CPB + 1);
    chk("def_idle_line", tx_pin_out_d, 1'b1);

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
